uart_rx_os4: RTL and testbench

//  UART receiver consuming the 4x-baud tick from the baud generator (tick = 1-clk pulse, 4 per bit).

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_bit.sv | 29 ++
 rtl/uart_rx_os4.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_os4.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding and oversampling constants for uart_rx_os4.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int OSR    = 4;
   localparam int TCNT_W = $clog2(OSR);

   localparam logic [TCNT_W-1:0] MID_TICK  = TCNT_W'(1);
   localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(OSR - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      WAIT_HI = 3'd5
   } state_t;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Brief    : Flop-chain synchroniser for one async bit, resets to idle-high.
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_chain <= '1;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], d};
      end
   end

   assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_os4.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os4
// Brief    : 4x-oversampled UART receiver with valid/ready holding register.
//            Define UART_RX_PARITY_EN to add an even-parity bit to the frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os4
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 tick,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 parity_err
);

`ifdef UART_RX_PARITY_EN
   localparam logic c_PAR_EN = 1'b1;
`else
   localparam logic c_PAR_EN = 1'b0;
`endif

   logic                 w_rxd_s;
   state_t               r_state,  w_state_nxt;
   logic [TCNT_W-1:0]    r_tcnt,   w_tcnt_nxt;
   logic [2:0]           r_bcnt,   w_bcnt_nxt;
   logic [DATA_BITS-1:0] r_shreg,  w_shreg_nxt;
   logic                 r_par_bad, w_par_bad_nxt;
   logic                 w_load;
   logic                 w_ferr;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_overrun;
   logic                 r_frame_err;
   logic                 r_parity_err;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync_rxd (
      .clk    (clk),
      .resetn (resetn),
      .d      (rxd),
      .q      (w_rxd_s)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_tcnt_nxt    = r_tcnt;
      w_bcnt_nxt    = r_bcnt;
      w_shreg_nxt   = r_shreg;
      w_par_bad_nxt = r_par_bad;
      w_load        = 1'b0;
      w_ferr        = 1'b0;
      if (tick) begin
         case (r_state)
            IDLE: begin
               if (!w_rxd_s) begin
                  w_state_nxt   = START;
                  w_tcnt_nxt    = '0;
                  w_par_bad_nxt = 1'b0;
               end
            end
            START: begin
               w_tcnt_nxt = r_tcnt + 1'b1;
               // Line still low near mid start bit: real frame, else a glitch.
               if (r_tcnt == MID_TICK) begin
                  w_tcnt_nxt = '0;
                  if (!w_rxd_s) begin
                     w_state_nxt = DATA;
                     w_bcnt_nxt  = '0;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end
            end
            DATA: begin
               w_tcnt_nxt = r_tcnt + 1'b1;
               if (r_tcnt == LAST_TICK) begin
                  w_shreg_nxt = {w_rxd_s, r_shreg[DATA_BITS-1:1]};
                  w_bcnt_nxt  = r_bcnt + 1'b1;
                  if (r_bcnt == 3'(DATA_BITS - 1)) begin
                     w_state_nxt = c_PAR_EN ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               w_tcnt_nxt = r_tcnt + 1'b1;
               if (r_tcnt == LAST_TICK) begin
                  w_par_bad_nxt = (w_rxd_s != even_parity(8'(r_shreg)));
                  w_state_nxt   = STOP;
               end
            end
            STOP: begin
               w_tcnt_nxt = r_tcnt + 1'b1;
               if (r_tcnt == LAST_TICK) begin
                  if (w_rxd_s) begin
                     w_load      = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_ferr      = 1'b1;
                     w_state_nxt = WAIT_HI;
                  end
               end
            end
            WAIT_HI: begin
               if (w_rxd_s) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_tcnt       <= '0;
         r_bcnt       <= '0;
         r_shreg      <= '0;
         r_par_bad    <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tcnt       <= w_tcnt_nxt;
         r_bcnt       <= w_bcnt_nxt;
         r_shreg      <= w_shreg_nxt;
         r_par_bad    <= w_par_bad_nxt;
         r_frame_err  <= w_ferr;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
         // A new byte always wins over a same-cycle accept.
         if (w_load) begin
            r_rx_data    <= r_shreg;
            r_rx_valid   <= 1'b1;
            r_overrun    <= r_rx_valid & ~rx_ready;
            r_parity_err <= r_par_bad & c_PAR_EN;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign overrun    = r_overrun;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os4.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os4
// Brief    : Directed bench for uart_rx_os4 (honours UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os4;

`ifdef UART_RX_PARITY_EN
   localparam int c_PBITS = 1;
`else
   localparam int c_PBITS = 0;
`endif

   logic       clk      = 1'b0;
   logic       resetn   = 1'b0;
   logic       tick     = 1'b0;
   logic       rxd      = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;

   int n_tests = 0;
   int n_fail  = 0;

   int   n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0;
   int   s_ferr, s_ovr, s_perr, s_rise;
   logic prev_valid = 1'b0;

   uart_rx_os4 #(
      .DATA_BITS   (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .tick       (tick),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #10 clk = ~clk;

   // 50 MHz clock, 460.8 kHz tick: phase accumulator 1152/125000
   initial begin : g_tickgen
      int acc;
      acc = 0;
      forever begin
         @(posedge clk);
         #1;
         acc = acc + 1152;
         if (acc >= 125000) begin
            acc  = acc - 125000;
            tick = 1'b1;
         end else begin
            tick = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
      if (rx_valid && !prev_valid) n_rise++;
      prev_valid = rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_ferr = n_ferr;
      s_ovr  = n_ovr;
      s_perr = n_perr;
      s_rise = n_rise;
   endtask

   // Returns positioned at the negedge inside a tick cycle.
   task automatic next_tick();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!tick && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!tick) begin
         n_tests++;
         n_fail++;
         $display("FAIL tick_timeout: observed no tick, expected one within 1000 clk");
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) next_tick();
   endtask

   // Line value set at tick k is seen by the receiver from tick k+1; the
   // stop bit is set at tick 4*(9+P) and sampled at tick 4*(9+P)+3.
   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input logic par_flip, input logic ready_at_load);
      next_tick();
      rxd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ticks(4);
         rxd = b[i];
      end
      if (c_PBITS != 0) begin
         ticks(4);
         rxd = (^b) ^ par_flip;
      end
      ticks(4);
      rxd = stop_v;
      ticks(3);
      if (ready_at_load) begin
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
      end
      ticks(1);
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  32'(rx_valid),   32'h0);
      check({tag, "_data"},   32'(rx_data),    32'h0);
      check({tag, "_ovr"},    32'(overrun),    32'h0);
      check({tag, "_ferr"},   32'(frame_err),  32'h0);
      check({tag, "_perr"},   32'(parity_err), 32'h0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;
      ticks(8);

      // Clean 0xA5, consumer not ready
      snap();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      rxd = 1'b1;
      ticks(2);
      check("a5_data",  32'(rx_data),  32'hA5);
      check("a5_valid", 32'(rx_valid), 32'h1);
      check("a5_ferr",  32'(n_ferr - s_ferr), 32'd0);
      check("a5_ovr",   32'(n_ovr - s_ovr),   32'd0);
      check("a5_perr",  32'(n_perr - s_perr), 32'd0);
      drain();
      check("drain_valid", 32'(rx_valid), 32'h0);
      check("drain_data",  32'(rx_data),  32'hA5);

      // One-tick start glitch
      snap();
      next_tick();
      rxd = 1'b0;
      next_tick();
      rxd = 1'b1;
      ticks(12);
      check("glitch_valid", 32'(rx_valid), 32'h0);
      check("glitch_rise",  32'(n_rise - s_rise), 32'd0);
      check("glitch_ferr",  32'(n_ferr - s_ferr), 32'd0);

      // 0x3C with stop low, then line held low for 20 bit times
      snap();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      ticks(80);
      check("ferr_pulse", 32'(n_ferr - s_ferr), 32'd1);
      check("ferr_valid", 32'(rx_valid), 32'h0);
      check("ferr_rise",  32'(n_rise - s_rise), 32'd0);
      rxd = 1'b1;
      ticks(8);
      check("break_rise", 32'(n_rise - s_rise), 32'd0);
      check("break_ferr", 32'(n_ferr - s_ferr), 32'd1);

      // Back-to-back 0x11, 0x22 without draining
      snap();
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      rxd = 1'b1;
      ticks(4);
      check("b2b_ovr",   32'(n_ovr - s_ovr),   32'd1);
      check("b2b_data",  32'(rx_data),  32'h22);
      check("b2b_valid", 32'(rx_valid), 32'h1);
      check("b2b_rise",  32'(n_rise - s_rise), 32'd1);

      // Accept of 0x22 lands on the same clk as the load of 0x55
      snap();
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      rxd = 1'b1;
      ticks(2);
      check("lda_valid", 32'(rx_valid), 32'h1);
      check("lda_data",  32'(rx_data),  32'h55);
      check("lda_ovr",   32'(n_ovr - s_ovr),   32'd0);
      check("lda_rise",  32'(n_rise - s_rise), 32'd0);
      drain();

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight, so even parity bit should be 1; send 0
      snap();
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      rxd = 1'b1;
      ticks(2);
      check("par_bad_pulse", 32'(n_perr - s_perr), 32'd1);
      check("par_bad_data",  32'(rx_data),  32'h07);
      check("par_bad_valid", 32'(rx_valid), 32'h1);
      drain();
      snap();
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      rxd = 1'b1;
      ticks(2);
      check("par_ok_pulse", 32'(n_perr - s_perr), 32'd0);
      check("par_ok_data",  32'(rx_data),  32'h07);
      drain();
`endif

      // Reset in the middle of the data bits
      next_tick();
      rxd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ticks(4);
         rxd = i[0];
      end
      ticks(2);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("midrst");
      rxd = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      ticks(12);
      snap();
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      rxd = 1'b1;
      ticks(2);
      check("post_rst_data",  32'(rx_data),  32'h81);
      check("post_rst_valid", 32'(rx_valid), 32'h1);
      check("post_rst_ferr",  32'(n_ferr - s_ferr), 32'd0);
      check("post_rst_perr",  32'(n_perr - s_perr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
